// File: rtl/regfile_param.sv
// Parametrised 1W/NUM_RD-R register file with sequenced clear engine, written tracking and write-to-read bypass.
// Reads are combinational (0 cycles), writes land on the clock edge; ready=0 while clearing. Optional macro: REGFILE_ZERO_REG_EN.
module regfile_param #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_written
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("regfile_param: DEPTH must be at least 2");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_nrd
      $error("regfile_param: NUM_RD must be in 1..4");
    end
  endgenerate

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DEPTH-1:0]  written;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic wr_in_range;
  logic wr_ok;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
  // A clear request in the same cycle as a write always wins.
  assign wr_ok = ready && wr_en && !clr_req && wr_in_range &&
                 !(ZERO_REG && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
      written <= '0;
    end else begin
      case (state)
        CLEAR: begin
          written[clr_ptr] <= 1'b0;
          if (clr_req) begin
            clr_ptr <= '0;
          end else if (clr_ptr == LAST_IDX) begin
            clr_ptr <= '0;
            state   <= READY;
            ready   <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        READY: begin
          if (clr_req) begin
            clr_ptr <= '0;
            state   <= CLEAR;
            ready   <= 1'b0;
          end else if (wr_ok) begin
            written[wr_addr] <= 1'b1;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Storage is not reset; the clear engine zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  logic [ADDR_W-1:0] ra;

  always_comb begin
    rd_data    = '0;
    rd_written = '0;
    ra         = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = rd_addr[p*ADDR_W +: ADDR_W];
      if (ready && ({1'b0, ra} < DEPTH_C)) begin
        if (ZERO_REG && (ra == '0)) begin
          rd_written[p] = 1'b1;
        end else if (wr_en && (wr_addr == ra)) begin
          rd_data[p*WIDTH +: WIDTH] = wr_data;
          rd_written[p]             = 1'b1;
        end else begin
          rd_data[p*WIDTH +: WIDTH] = mem[ra];
          rd_written[p]             = written[ra];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Randomised scoreboard bench: a 16-entry/2-port instance and a 12-entry/3-port instance share one stimulus stream.
// Expected reads come from a queue/array reference model; a negedge monitor pops and compares.
module tb_regfile_param;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  localparam int DEP_A = 16;
  localparam int DEP_B = 12;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clr_req;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [11:0] rd_addr;

  logic        rdy_a, rdy_b;
  logic [31:0] rdd_a;
  logic [1:0]  rdw_a;
  logic [47:0] rdd_b;
  logic [2:0]  rdw_b;

  regfile_param #(.WIDTH(16), .DEPTH(DEP_A), .NUM_RD(2)) dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(rdy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr[7:0]), .rd_data(rdd_a), .rd_written(rdw_a)
  );

  regfile_param #(.WIDTH(16), .DEPTH(DEP_B), .NUM_RD(3)) dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(rdy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd_b), .rd_written(rdw_b)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  rdy;
    logic [95:0] d;
    logic [5:0]  w;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  // Reference model: contents, written flags, and clear cycles still to go (0 = usable).
  logic [15:0] m_mem [2][16];
  logic        m_wr  [2][16];
  int          m_left[2];
  int          dep   [2] = '{DEP_A, DEP_B};

  function automatic void model_reset(input int k);
    m_left[k] = dep[k];
    for (int i = 0; i < 16; i++) begin
      m_mem[k][i] = 16'h0;
      m_wr[k][i]  = 1'b0;
    end
  endfunction

  function automatic void model_rd(input int k, input logic [3:0] a,
                                   output logic [15:0] d, output logic w);
    d = 16'h0;
    w = 1'b0;
    if (m_left[k] != 0 || int'(a) >= dep[k]) return;
    if (ZR && a == 4'd0) begin
      w = 1'b1;
    end else if (wr_en && wr_addr == a) begin
      d = wr_data;
      w = 1'b1;
    end else begin
      d = m_mem[k][a];
      w = m_wr[k][a];
    end
  endfunction

  function automatic void model_edge(input int k);
    if (m_left[k] > 0) begin
      m_left[k] = clr_req ? dep[k] : m_left[k] - 1;
    end else if (clr_req) begin
      model_reset(k);
    end else if (wr_en && int'(wr_addr) < dep[k] && !(ZR && wr_addr == 4'd0)) begin
      m_mem[k][wr_addr] = wr_data;
      m_wr[k][wr_addr]  = 1'b1;
    end
  endfunction

  task automatic step(input logic r, input logic c, input logic we,
                      input logic [3:0] wa, input logic [15:0] wd, input logic [11:0] ra);
    exp_t        e;
    logic [15:0] d;
    logic        w;
    @(posedge clk);
    #1;
    rst = r; clr_req = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    if (!r) begin
      model_reset(0);
      model_reset(1);
    end
    e.cyc = cyc;
    e.d   = '0;
    e.w   = '0;
    for (int k = 0; k < 2; k++) begin
      e.rdy[k] = (m_left[k] == 0);
      for (int p = 0; p < (k == 0 ? 2 : 3); p++) begin
        model_rd(k, ra[p*4 +: 4], d, w);
        e.d[k*48 + p*16 +: 16] = d;
        e.w[k*3 + p]           = w;
      end
    end
    sb_q.push_back(e);
    if (r) begin
      model_edge(0);
      model_edge(1);
    end
    cyc++;
  endtask

  task automatic chk(input string nm, input int c, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got written=%0b data=%h, expected written=%0b data=%h",
               nm, c, got[16], got[15:0], exp[16], exp[15:0]);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ready_a", e.cyc, {16'h0, rdy_a}, {16'h0, e.rdy[0]});
        chk("ready_b", e.cyc, {16'h0, rdy_b}, {16'h0, e.rdy[1]});
        for (int p = 0; p < 2; p++)
          chk($sformatf("a_port%0d", p), e.cyc, {rdw_a[p], rdd_a[p*16 +: 16]},
              {e.w[p], e.d[p*16 +: 16]});
        for (int p = 0; p < 3; p++)
          chk($sformatf("b_port%0d", p), e.cyc, {rdw_b[p], rdd_b[p*16 +: 16]},
              {e.w[3 + p], e.d[48 + p*16 +: 16]});
      end
    end
  end

  function automatic logic [11:0] rnd_ra();
    return 12'($urandom_range(0, 4095));
  endfunction

  initial begin : stim
    logic [3:0] wa;
    rst = 1'b0; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    model_reset(0);
    model_reset(1);

    step(0, 0, 0, 0, 0, 12'h000);
    step(0, 0, 0, 0, 0, 12'h321);
    // Idle after release: ready must rise after exactly DEPTH edges per instance.
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, rnd_ra());

    step(1, 0, 1, 4'd5, 16'hBEEF, 12'h055);
    step(1, 0, 0, 4'd0, 16'h0000, 12'h555);
    step(1, 0, 1, 4'd7, 16'h1234, 12'h007);
    step(1, 0, 0, 4'd0, 16'h0000, 12'h777);

    for (int i = 1; i < 16; i++) step(1, 0, 1, 4'(i), 16'($urandom), rnd_ra());
    step(1, 1, 0, 0, 0, rnd_ra());
    for (int i = 0; i < 4; i++) step(1, 0, 1, 4'(i + 3), 16'hDEAD, rnd_ra());
    step(1, 1, 0, 0, 0, rnd_ra());
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, rnd_ra());

    step(1, 0, 1, 4'd13, 16'hAAAA, 12'hDDD);
    step(1, 0, 0, 4'd0, 16'h0000, 12'hDDD);
    step(1, 0, 1, 4'd0, 16'hFFFF, 12'h000);
    step(1, 0, 0, 4'd1, 16'h0000, 12'h000);

    // Clear request colliding with a write: the write must be dropped.
    step(1, 1, 1, 4'd9, 16'h9999, 12'h999);
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0, 0, 12'h999);

    for (int i = 0; i < 800; i++) begin
      wa = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) < 1) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           wa, 16'($urandom),
           ($urandom_range(0, 3) == 0) ? {wa, wa, wa} : rnd_ra());
    end

    step(1, 0, 0, 0, 0, 12'h000);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
